// File: rtl/lbm_probe_capture.sv
// lbm_probe_capture: averages one LBM node over 2^AVG_LOG2 frames and publishes a PIO-stable result.
// Optional sticky miss flag built only when LBM_PROBE_MISS_EN is defined.
module lbm_probe_capture #(
  parameter int DATA_W   = 27,
  parameter int IDX_W    = 12,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  probe_idx,
  input  logic              probe_load,
  input  logic              freeze,
  input  logic              s_valid,
  input  logic [IDX_W-1:0]  s_idx,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_frame_end,
  output logic [DATA_W-1:0] out_value,
  output logic              out_valid,
  output logic [3:0]        out_seq,
  output logic              out_miss
);
  localparam int AW = DATA_W + AVG_LOG2;
  localparam int FW = AVG_LOG2 + 1;
  localparam logic [1:0] WAIT_FRAME = 2'd0, ACCUM = 2'd1, PUBLISH = 2'd2;
  logic [1:0] state_q, state_d;
  logic [IDX_W-1:0] probe_q;
  logic signed [AW-1:0] acc_q, acc_d, acc_base, acc_shift;
  logic [FW-1:0] frames_q, frames_d, frames_base;
  logic hit_q, hit_d, pend_q, pend_d, valid_q, valid_d;
  logic [DATA_W-1:0] sample_q, sample_d, pend_val_q, pend_val_d, value_q, value_d, samp_eff;
  logic [3:0] seq_q, seq_d;
  logic live, pub_cyc, beat_hit, closing, frame_hit, pub;
  always_comb begin
    live        = state_q != WAIT_FRAME;
    pub_cyc     = state_q == PUBLISH;
    beat_hit    = s_valid && s_idx == probe_q;
    closing     = live && s_valid && s_frame_end;
    frame_hit   = hit_q || beat_hit;
    samp_eff    = beat_hit ? s_data : sample_q;
    acc_shift   = acc_q >>> AVG_LOG2;
    // publish runs alongside capture, so the next frame starts from a cleared sum
    acc_base    = pub_cyc ? '0 : acc_q;
    frames_base = pub_cyc ? '0 : frames_q;
    acc_d       = closing && frame_hit ? acc_base + AW'($signed(samp_eff)) : acc_base;
    frames_d    = frames_base + FW'(closing && frame_hit);
    hit_d       = !closing && (hit_q || (live && beat_hit));
    sample_d    = live && beat_hit ? s_data : sample_q;
    state_d     = !live ? (s_valid && s_frame_end ? ACCUM : WAIT_FRAME)
                : (frames_d == FW'(1 << AVG_LOG2) ? PUBLISH : ACCUM);
    pub         = !freeze && (pub_cyc || pend_q);
    pend_d      = freeze && (pub_cyc || pend_q);
    pend_val_d  = pub_cyc ? acc_shift[DATA_W-1:0] : pend_val_q;
    value_d     = pub ? pend_val_d : value_q;
    seq_d       = seq_q + 4'(pub);
    valid_d     = valid_q || pub;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WAIT_FRAME;
      probe_q    <= '0;
      acc_q      <= '0;
      frames_q   <= '0;
      hit_q      <= 1'b0;
      sample_q   <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      value_q    <= '0;
      seq_q      <= '0;
      valid_q    <= 1'b0;
    end else if (probe_load) begin
      state_q  <= WAIT_FRAME;
      probe_q  <= probe_idx;
      acc_q    <= '0;
      frames_q <= '0;
      hit_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      frames_q   <= frames_d;
      hit_q      <= hit_d;
      sample_q   <= sample_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      value_q    <= value_d;
      seq_q      <= seq_d;
      valid_q    <= valid_d;
    end
  end
`ifdef LBM_PROBE_MISS_EN
  logic miss_q;
  always_ff @(posedge clk) begin
    if (reset || probe_load) miss_q <= 1'b0;
    else miss_q <= (miss_q && !pub) || (closing && !frame_hit);
  end
  assign out_miss = miss_q;
`else
  assign out_miss = 1'b0;
`endif
  assign out_value = value_q;
  assign out_seq   = seq_q;
  assign out_valid = valid_q;
endmodule
